// File: rtl/nv_nvdla_sdp_nrdma_eg_ctx.sv
// NRDMA egress context consumer: pops request contexts, counts response atoms against them,
// forwards beats through one registered stage and returns latency-FIFO credits.
module nv_nvdla_sdp_nrdma_eg_ctx #(
  parameter int unsigned ATOM_W = 256,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  cq2eg_pvld,
  output logic                  cq2eg_prdy,
  input  logic [15:0]           cq2eg_pd,
  input  logic                  rsp_pvld,
  output logic                  rsp_prdy,
  input  logic [2*ATOM_W-1:0]   rsp_data,
  input  logic [1:0]            rsp_mask,
  output logic                  out_pvld,
  input  logic                  out_prdy,
  output logic [2*ATOM_W-1:0]   out_data,
  output logic [1:0]            out_mask,
  output logic                  out_req_end,
  output logic                  out_layer_end,
  output logic                  lat_cdt_vld,
  output logic [1:0]            lat_cdt_cnt,
  output logic                  err_overrun,
  output logic                  eg_idle
);

  localparam int unsigned RW = CNT_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   remaining;
  logic [RW-1:0]   remaining_nxt;
  logic            layer_last_q;
  logic            layer_last_nxt;

  logic            stage_free;
  logic            rsp_acc;
  logic [1:0]      beat_atoms;
  logic            beat_final;
  logic            beat_err;
  logic [1:0]      beat_cdt;
  logic            pd_unused;

  // Context payload bits above layer_last carry nothing for this block.
  assign pd_unused  = ^cq2eg_pd[15:5];

  assign stage_free = !out_pvld || out_prdy;
  assign rsp_acc    = (state == ST_RUN) && rsp_pvld && stage_free;
  assign beat_atoms = 2'({1'b0, rsp_mask[0]} + {1'b0, rsp_mask[1]});
  assign beat_final = RW'(beat_atoms) >= remaining;
  // Overrun past the request, or an atom-1-only / empty beat, is a protocol error.
  assign beat_err   = (RW'(beat_atoms) > remaining) || !rsp_mask[0];
  assign beat_cdt   = (beat_atoms == 2'd0) ? 2'd1 : beat_atoms;

  // Context state register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      layer_last_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      layer_last_q <= layer_last_nxt;
    end
  end

  // Next-state and handshake decode; a context reloads in the same cycle as a final beat.
  always_comb begin
    state_nxt      = state;
    remaining_nxt  = remaining;
    layer_last_nxt = layer_last_q;
    cq2eg_prdy     = 1'b0;
    rsp_prdy       = 1'b0;
    case (state)
      ST_IDLE: begin
        cq2eg_prdy = 1'b1;
        if (cq2eg_pvld) begin
          state_nxt      = ST_RUN;
          remaining_nxt  = RW'(cq2eg_pd[CNT_W-1:0]) + RW'(1);
          layer_last_nxt = cq2eg_pd[4];
        end
      end
      ST_RUN: begin
        rsp_prdy = stage_free;
        if (rsp_acc) begin
          if (beat_final) begin
            cq2eg_prdy = 1'b1;
            if (cq2eg_pvld) begin
              remaining_nxt  = RW'(cq2eg_pd[CNT_W-1:0]) + RW'(1);
              layer_last_nxt = cq2eg_pd[4];
            end else begin
              state_nxt      = ST_IDLE;
              remaining_nxt  = '0;
              layer_last_nxt = 1'b0;
            end
          end else begin
            remaining_nxt = remaining - RW'(beat_atoms);
          end
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        remaining_nxt = '0;
      end
    endcase
  end

  // Output stage control and flags.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_pvld      <= 1'b0;
      out_mask      <= 2'b00;
      out_req_end   <= 1'b0;
      out_layer_end <= 1'b0;
    end else if (rsp_acc) begin
      out_pvld      <= 1'b1;
      out_mask      <= rsp_mask;
      out_req_end   <= beat_final;
      out_layer_end <= beat_final && layer_last_q;
    end else if (out_prdy) begin
      out_pvld      <= 1'b0;
    end
  end

  // Data path is qualified by out_pvld, so it carries no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (rsp_acc) begin
      out_data <= rsp_data;
    end
  end

  // Credit return and sticky error.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      lat_cdt_vld <= 1'b0;
      lat_cdt_cnt <= 2'd0;
      err_overrun <= 1'b0;
    end else begin
      lat_cdt_vld <= rsp_acc;
      lat_cdt_cnt <= rsp_acc ? beat_cdt : 2'd0;
      if (rsp_acc && beat_err) begin
        err_overrun <= 1'b1;
      end
    end
  end

  assign eg_idle = (state == ST_IDLE) && !out_pvld;

endmodule

// File: tb/tb_nv_nvdla_sdp_nrdma_eg_ctx.sv
// Scoreboard bench for nv_nvdla_sdp_nrdma_eg_ctx: a reference model predicts output beats,
// credits, handshakes and error state from the stimulus queues.
module tb_nv_nvdla_sdp_nrdma_eg_ctx;

  localparam int unsigned ATOM_W = 256;
  localparam int unsigned DW     = 2 * ATOM_W;

  logic          clk;
  logic          rst_n;
  logic          cq2eg_pvld;
  logic          cq2eg_prdy;
  logic [15:0]   cq2eg_pd;
  logic          rsp_pvld;
  logic          rsp_prdy;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_mask;
  logic          out_pvld;
  logic          out_prdy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_mask;
  logic          out_req_end;
  logic          out_layer_end;
  logic          lat_cdt_vld;
  logic [1:0]    lat_cdt_cnt;
  logic          err_overrun;
  logic          eg_idle;

  nv_nvdla_sdp_nrdma_eg_ctx #(.ATOM_W(ATOM_W), .CNT_W(4)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .cq2eg_pvld      (cq2eg_pvld),
    .cq2eg_prdy      (cq2eg_prdy),
    .cq2eg_pd        (cq2eg_pd),
    .rsp_pvld        (rsp_pvld),
    .rsp_prdy        (rsp_prdy),
    .rsp_data        (rsp_data),
    .rsp_mask        (rsp_mask),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_data        (out_data),
    .out_mask        (out_mask),
    .out_req_end     (out_req_end),
    .out_layer_end   (out_layer_end),
    .lat_cdt_vld     (lat_cdt_vld),
    .lat_cdt_cnt     (lat_cdt_cnt),
    .err_overrun     (err_overrun),
    .eg_idle         (eg_idle)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    m;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    m;
    logic          re;
    logic          le;
  } exp_t;

  logic [15:0] ctx_q[$];
  beat_t       rsp_q[$];
  exp_t        exp_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;

  logic        ctx_fire = 1'b0;
  logic        rsp_fire = 1'b0;
  logic        mdl_busy = 1'b0;
  int          mdl_rem  = 0;
  logic        mdl_ll   = 1'b0;
  logic        mdl_err  = 1'b0;
  logic        cdt_pend = 1'b0;
  logic [1:0]  cdt_cnt  = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic push_ctx(input int cnt_m1, input logic ll);
    ctx_q.push_back({11'h0, ll, 4'(cnt_m1)});
  endtask

  task automatic push_beat(input logic [1:0] m);
    beat_t b;
    b.d = rnd_data();
    b.m = m;
    rsp_q.push_back(b);
  endtask

  task automatic wait_drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #2;
      done = (ctx_q.size() == 0) && (rsp_q.size() == 0) && !mdl_busy &&
             (exp_q.size() == 0) && !cdt_pend;
    end
    chk(tag, DW'(done), DW'(1'b1));
  endtask

  // Input driver: presents queued contexts and beats, retiring them after each handshake.
  initial begin
    beat_t tmp_b;
    logic [15:0] tmp_c;
    cq2eg_pvld = 1'b0;
    cq2eg_pd   = 16'h0;
    rsp_pvld   = 1'b0;
    rsp_data   = '0;
    rsp_mask   = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (ctx_fire && ctx_q.size() != 0) tmp_c = ctx_q.pop_front();
      if (rsp_fire && rsp_q.size() != 0) tmp_b = rsp_q.pop_front();
      cq2eg_pvld = (ctx_q.size() != 0);
      if (ctx_q.size() != 0) cq2eg_pd = ctx_q[0];
      rsp_pvld = (rsp_q.size() != 0);
      if (rsp_q.size() != 0) begin
        rsp_data = rsp_q[0].d;
        rsp_mask = rsp_q[0].m;
      end
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    logic busy_before;
    logic exp_rdy;
    logic fin;
    int   pc;
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_pvld", DW'(out_pvld), DW'(1'b0));
      chk("rst_cdt_vld", DW'(lat_cdt_vld), DW'(1'b0));
      chk("rst_err", DW'(err_overrun), DW'(1'b0));
      chk("rst_idle", DW'(eg_idle), DW'(1'b1));
      chk("rst_req_end", DW'(out_req_end), DW'(1'b0));
      ctx_fire = 1'b0;
      rsp_fire = 1'b0;
      mdl_busy = 1'b0;
      mdl_rem  = 0;
      mdl_err  = 1'b0;
      cdt_pend = 1'b0;
      exp_q.delete();
    end else begin
      busy_before = mdl_busy;
      chk("out_pvld", DW'(out_pvld), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_data", out_data, e.d);
        chk("out_mask", DW'(out_mask), DW'(e.m));
        chk("out_req_end", DW'(out_req_end), DW'(e.re));
        chk("out_layer_end", DW'(out_layer_end), DW'(e.le));
      end
      chk("cdt_vld", DW'(lat_cdt_vld), DW'(cdt_pend));
      if (cdt_pend) chk("cdt_cnt", DW'(lat_cdt_cnt), DW'(cdt_cnt));
      chk("err_overrun", DW'(err_overrun), DW'(mdl_err));
      chk("eg_idle", DW'(eg_idle), DW'(!mdl_busy && exp_q.size() == 0));
      exp_rdy = mdl_busy && (exp_q.size() == 0 || out_prdy);
      chk("rsp_prdy", DW'(rsp_prdy), DW'(exp_rdy));

      ctx_fire = cq2eg_pvld && cq2eg_prdy;
      rsp_fire = rsp_pvld && rsp_prdy;

      if (out_pvld && out_prdy && exp_q.size() != 0) e = exp_q.pop_front();
      cdt_pend = 1'b0;
      fin = 1'b0;
      if (rsp_pvld && exp_rdy) begin
        pc  = int'(rsp_mask[0]) + int'(rsp_mask[1]);
        fin = (pc >= mdl_rem);
        e.d = rsp_data;
        e.m = rsp_mask;
        e.re = fin;
        e.le = fin && mdl_ll;
        exp_q.push_back(e);
        cdt_pend = 1'b1;
        cdt_cnt  = (pc == 0) ? 2'd1 : 2'(pc);
        if (pc > mdl_rem || !rsp_mask[0]) mdl_err = 1'b1;
        if (fin) begin
          mdl_busy = 1'b0;
          mdl_rem  = 0;
        end else begin
          mdl_rem = mdl_rem - pc;
        end
      end
      chk("cq2eg_prdy", DW'(cq2eg_prdy), DW'(!busy_before || fin));
      if (cq2eg_pvld && (!busy_before || fin)) begin
        mdl_busy = 1'b1;
        mdl_rem  = int'(cq2eg_pd[3:0]) + 1;
        mdl_ll   = cq2eg_pd[4];
      end
    end
  end

  initial begin
    logic hit;
    int   rem;
    rst_n    = 1'b0;
    out_prdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Four-atom request in two full beats.
    push_ctx(3, 1'b0);
    push_beat(2'b11); push_beat(2'b11);
    wait_drain("t1_drain");

    // Single atom, layer end.
    push_ctx(0, 1'b1);
    push_beat(2'b01);
    wait_drain("t2_drain");

    // Back-to-back contexts reloaded on the final beat.
    push_ctx(1, 1'b0); push_ctx(1, 1'b1);
    push_beat(2'b11); push_beat(2'b11);
    wait_drain("t3_drain");

    // Downstream stall mid-request.
    push_ctx(7, 1'b0);
    for (int i = 0; i < 4; i++) push_beat(2'b11);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #2;
      hit = mdl_busy && (mdl_rem <= 6);
    end
    chk("t4_first_beat", DW'(hit), DW'(1'b1));
    @(posedge clk); #1 out_prdy = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_prdy = 1'b1;
    wait_drain("t4_drain");

    // Overrun: one atom requested, two delivered.
    push_ctx(0, 1'b0);
    push_beat(2'b11);
    wait_drain("t5_drain");

    // Illegal masks 10 and 00 still forwarded and counted.
    push_ctx(1, 1'b1);
    push_beat(2'b10); push_beat(2'b00); push_beat(2'b01);
    wait_drain("t5b_drain");

    // Random legal traffic with random backpressure.
    for (int c = 0; c < 6; c++) begin
      rem = $urandom_range(0, 15);
      push_ctx(rem, 1'($urandom_range(0, 1)));
      rem = rem + 1;
      while (rem > 0) begin
        if (rem == 1 || $urandom_range(0, 2) == 0) begin
          push_beat(2'b01); rem = rem - 1;
        end else begin
          push_beat(2'b11); rem = rem - 2;
        end
      end
    end
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1 out_prdy = 1'($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 out_prdy = 1'b1;
    wait_drain("rand_drain");

    // Reset with four atoms still outstanding.
    push_ctx(5, 1'b1);
    push_beat(2'b11);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #2;
      hit = mdl_busy && (mdl_rem == 4) && (exp_q.size() == 0) && !cdt_pend;
    end
    chk("t6_partial", DW'(hit), DW'(1'b1));
    @(posedge clk); #1 rst_n = 1'b0;
    ctx_q.delete();
    rsp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_ctx(0, 1'b1);
    push_beat(2'b01);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
